// File: rtl/sub_tc_iter_pkg.sv
// Shared arithmetic definitions for the iterative subtractor.
// Holds the FSM state type, the default group size and the group-count helper.
package sub_tc_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GRP_DEF = 4;

    function automatic int ng_of(input int width, input int grp);
        return width / grp;
    endfunction

endpackage

// File: rtl/sub_tc_iter_if.sv
// Operand/result handshake bundle for sub_tc_iter.
// The master issues operands and consumes results; the slave is the subtractor.
interface sub_tc_iter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, ovf
    );
endinterface

// File: rtl/sub_tc_iter_grp_add.sv
// GRP-bit group adder with carry-in/carry-out and group propagate/generate.
// P/G are exported so a lookahead carry chain can be built from several groups.
module grp_add #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    input  logic           ci,
    output logic [GRP-1:0] sum,
    output logic           co,
    output logic           p,
    output logic           g
);
    logic [GRP:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{GRP{1'b0}}, ci};
    assign sum  = full[GRP-1:0];
    assign co   = full[GRP];
    assign p    = &(a ^ b);
    // When every bit propagates, the carry-out is just the carry-in, so no generate.
    assign g    = full[GRP] & ~p;
endmodule

// File: rtl/sub_tc_iter.sv
// Iterative two's-complement subtractor: diff = a - b as an exact (WIDTH+1)-bit result.
// One GRP-bit group is summed per clock as a + ~b + 1 with a registered carry.
module sub_tc_iter
    import sub_tc_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = GRP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sub_tc_iter_if.slave bus
);
    localparam int NG    = ng_of(WIDTH, GRP);
    localparam int CNT_W = (NG > 1) ? $clog2(NG) : 1;
    localparam int SH_W  = $clog2(WIDTH + 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   diff_reg;
    logic             ovf_reg;

    logic [SH_W-1:0]  base;
    logic [GRP-1:0]   a_g;
    logic [GRP-1:0]   nb_g;
    logic [GRP-1:0]   grp_sum;
    logic             grp_co;
    logic             grp_p;
    logic             grp_g;
    logic             last;
    logic             top_bit;
    logic [WIDTH:0]   grp_mask;
    logic [WIDTH:0]   grp_bits;
    logic [WIDTH:0]   diff_run;

    assign base = SH_W'(cnt) * SH_W'(GRP);
    assign a_g  = GRP'(a_reg >> base);
    assign nb_g = GRP'(nb_reg >> base);
    assign last = (cnt == CNT_W'(NG - 1));

    grp_add #(.GRP(GRP)) u_grp_add (
        .a   (a_g),
        .b   (nb_g),
        .ci  (carry),
        .sum (grp_sum),
        .co  (grp_co),
        .p   (grp_p),
        .g   (grp_g)
    );

    // Sign bit of the exact result: both operands sign-extended by one bit.
    assign top_bit  = a_reg[WIDTH-1] ^ nb_reg[WIDTH-1] ^ grp_co;
    assign grp_mask = {{(WIDTH + 1 - GRP){1'b0}}, {GRP{1'b1}}} << base;
    assign grp_bits = {{(WIDTH + 1 - GRP){1'b0}}, grp_sum} << base;

    always_comb begin
        diff_run = (diff_reg & ~grp_mask) | grp_bits;
        if (last) begin
            diff_run[WIDTH] = top_bit;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Carry into the next group uses the lookahead form so P/G stay live.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            nb_reg   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            diff_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg    <= bus.a;
                        nb_reg   <= ~bus.b;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        diff_reg <= '0;
                        ovf_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    diff_reg <= diff_run;
                    carry    <= grp_g | (grp_p & carry);
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        ovf_reg <= top_bit ^ grp_sum[GRP-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_reg;
    assign bus.ovf       = ovf_reg;
endmodule
